// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: opcodes, widths, mul FSM states and the EX->MEM bundle.
package ex_stage_pkg;

  localparam int D_SIZE        = 32;
  localparam int ADDR_LINE_REG = 5;

  typedef enum logic [5:0] {
    OP_ADD  = 6'h00, OP_ADDI = 6'h01,
    OP_SUB  = 6'h02, OP_SUBI = 6'h03,
    OP_MUL  = 6'h04, OP_MULI = 6'h05,
    OP_OR   = 6'h06, OP_ORI  = 6'h07,
    OP_AND  = 6'h08, OP_ANDI = 6'h09,
    OP_XOR  = 6'h0A, OP_XORI = 6'h0B,
    OP_LDW  = 6'h0C, OP_STW  = 6'h0D,
    OP_BZ   = 6'h0E, OP_BEQ  = 6'h0F,
    OP_JR   = 6'h10, OP_HALT = 6'h11
  } opcode_e;

  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_BUSY = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

  typedef struct packed {
    logic [D_SIZE-1:0]        alu_result;
    logic [D_SIZE-1:0]        store_data;
    logic [ADDR_LINE_REG-1:0] rd;
    logic                     mem_read;
    logic                     mem_to_reg;
    logic                     mem_write;
  } ex_mem_t;

  // Register-form ALU ops are the even opcodes up to XOR; everything else takes the immediate.
  function automatic logic opb_is_reg(input logic [5:0] op);
    return (op <= 6'h0A) && !op[0];
  endfunction

  function automatic logic is_alu_mem(input logic [5:0] op);
    return op <= 6'h0D;
  endfunction

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Radix-2 shift-add multiplier with start/busy/done handshake (used when MUL_ITERATIVE_EN is defined).
// state    | meaning
// MUL_IDLE | waiting for start_i; operands latched on start
// MUL_BUSY | one shift-add step per cycle, MUL_STEPS steps
// MUL_DONE | product_o valid for one cycle, then back to idle
module mul_iter
  import ex_stage_pkg::*;
#(
  parameter int D_SIZE    = 32,
  parameter int MUL_STEPS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [D_SIZE-1:0] a_i,
  input  logic [D_SIZE-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [D_SIZE-1:0] product_o
);

  localparam int CNT_W = $clog2(MUL_STEPS + 1);

  logic [1:0]        state_q, state_d;
  logic [D_SIZE-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      MUL_IDLE: if (start_i) begin
        a_d     = a_i;
        b_d     = b_i;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = MUL_BUSY;
      end
      MUL_BUSY: begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_STEPS - 1)) state_d = MUL_DONE;
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MUL_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o    = (state_q == MUL_BUSY);
  assign done_o    = (state_q == MUL_DONE);
  assign product_o = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/HALT resolution and the registered EX->MEM bundle.
// Define MUL_ITERATIVE_EN to use the multi-cycle multiplier that stalls ID.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int D_SIZE    = 32,
  parameter int MUL_STEPS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [D_SIZE-1:0]        pc4_in_f_id,
  input  logic [5:0]               opcode_f_id,
  input  logic [D_SIZE-1:0]        rs_reg_value_f_id,
  input  logic [D_SIZE-1:0]        rt_reg_value_f_id,
  input  logic [ADDR_LINE_REG-1:0] rd_add_value_f_id,
  input  logic [D_SIZE-1:0]        i_data_f_id,
  input  logic                     branch_f_id,
  input  logic                     mem_read_f_id,
  input  logic                     mem_to_reg_f_id,
  input  logic                     mem_write_f_id,
  output logic [D_SIZE-1:0]        alu_result_2_mem,
  output logic [D_SIZE-1:0]        store_data_2_mem,
  output logic [ADDR_LINE_REG-1:0] rd_add_value_2_mem,
  output logic                     mem_read_2_mem,
  output logic                     mem_to_reg_2_mem,
  output logic                     mem_write_2_mem,
  output logic                     branch_taken_2_if,
  output logic [D_SIZE-1:0]        branch_target_2_if,
  output logic                     halt_2_if,
  output logic                     stall_2_id
);

  ex_mem_t           ex_mem_d, ex_mem_q;
  logic              br_taken_d, br_taken_q, halt_d, halt_q;
  logic [D_SIZE-1:0] br_target_d, br_target_q;
  logic [D_SIZE-1:0] op_b, mul_res, alu_res;
  logic              is_mul, kill, stall;
  logic              unused_branch;

  // Branch kind is decoded from the opcode here, so the ID branch flag is redundant.
  assign unused_branch = branch_f_id;
  assign kill   = br_taken_q | halt_q;
  assign is_mul = (opcode_f_id == OP_MUL) || (opcode_f_id == OP_MULI);
  assign op_b   = opb_is_reg(opcode_f_id) ? rt_reg_value_f_id : i_data_f_id;

`ifdef MUL_ITERATIVE_EN
  logic mul_busy, mul_done, start_mul;

  assign start_mul = is_mul & ~kill & ~mul_busy & ~mul_done;
  // Gated by reset so the stall output reads 0 while reset is held, like every other output.
  assign stall     = reset & (start_mul | mul_busy);

  mul_iter #(.D_SIZE(D_SIZE), .MUL_STEPS(MUL_STEPS)) u_mul_iter (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_mul),
    .a_i       (rs_reg_value_f_id),
    .b_i       (op_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_res)
  );
`else
  localparam int unused_mul_steps = MUL_STEPS;
  assign stall   = 1'b0;
  assign mul_res = rs_reg_value_f_id * op_b;
`endif

  always_comb begin
    alu_res = '0;
    case (opcode_f_id)
      OP_ADD, OP_ADDI, OP_LDW, OP_STW: alu_res = rs_reg_value_f_id + op_b;
      OP_SUB, OP_SUBI:                 alu_res = rs_reg_value_f_id - op_b;
      OP_MUL, OP_MULI:                 alu_res = mul_res;
      OP_OR,  OP_ORI:                  alu_res = rs_reg_value_f_id | op_b;
      OP_AND, OP_ANDI:                 alu_res = rs_reg_value_f_id & op_b;
      OP_XOR, OP_XORI:                 alu_res = rs_reg_value_f_id ^ op_b;
      default:                         alu_res = '0;
    endcase
  end

  always_comb begin
    ex_mem_d    = '0;
    br_taken_d  = 1'b0;
    br_target_d = '0;
    halt_d      = halt_q;
    if (!kill) begin
      case (opcode_f_id)
        OP_BZ:   br_taken_d = (rs_reg_value_f_id == '0);
        OP_BEQ:  br_taken_d = (rs_reg_value_f_id == rt_reg_value_f_id);
        OP_JR:   br_taken_d = 1'b1;
        OP_HALT: halt_d     = 1'b1;
        default: if (is_alu_mem(opcode_f_id) && !stall) begin
          ex_mem_d.alu_result = alu_res;
          ex_mem_d.store_data = rt_reg_value_f_id;
          ex_mem_d.rd         = rd_add_value_f_id;
          ex_mem_d.mem_read   = mem_read_f_id;
          ex_mem_d.mem_to_reg = mem_to_reg_f_id;
          ex_mem_d.mem_write  = mem_write_f_id;
        end
      endcase
      if (br_taken_d)
        br_target_d = (opcode_f_id == OP_JR) ? rs_reg_value_f_id
                                             : pc4_in_f_id + (i_data_f_id << 2);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_mem_q    <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      halt_q      <= 1'b0;
    end else begin
      ex_mem_q    <= ex_mem_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      halt_q      <= halt_d;
    end
  end

  assign alu_result_2_mem   = ex_mem_q.alu_result;
  assign store_data_2_mem   = ex_mem_q.store_data;
  assign rd_add_value_2_mem = ex_mem_q.rd;
  assign mem_read_2_mem     = ex_mem_q.mem_read;
  assign mem_to_reg_2_mem   = ex_mem_q.mem_to_reg;
  assign mem_write_2_mem    = ex_mem_q.mem_write;
  assign branch_taken_2_if  = br_taken_q;
  assign branch_target_2_if = br_target_q;
  assign halt_2_if          = halt_q;
  assign stall_2_id         = stall;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage; reference model follows the instruction rules, honours MUL_ITERATIVE_EN.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc4_in_f_id, rs_reg_value_f_id, rt_reg_value_f_id, i_data_f_id;
  logic [5:0]  opcode_f_id;
  logic [4:0]  rd_add_value_f_id;
  logic        branch_f_id, mem_read_f_id, mem_to_reg_f_id, mem_write_f_id;
  logic [31:0] alu_result_2_mem, store_data_2_mem, branch_target_2_if;
  logic [4:0]  rd_add_value_2_mem;
  logic        mem_read_2_mem, mem_to_reg_2_mem, mem_write_2_mem;
  logic        branch_taken_2_if, halt_2_if, stall_2_id;

  ex_stage #(.D_SIZE(32), .MUL_STEPS(32)) dut (
    .clk(clk), .reset(reset),
    .pc4_in_f_id(pc4_in_f_id), .opcode_f_id(opcode_f_id),
    .rs_reg_value_f_id(rs_reg_value_f_id), .rt_reg_value_f_id(rt_reg_value_f_id),
    .rd_add_value_f_id(rd_add_value_f_id), .i_data_f_id(i_data_f_id),
    .branch_f_id(branch_f_id), .mem_read_f_id(mem_read_f_id),
    .mem_to_reg_f_id(mem_to_reg_f_id), .mem_write_f_id(mem_write_f_id),
    .alu_result_2_mem(alu_result_2_mem), .store_data_2_mem(store_data_2_mem),
    .rd_add_value_2_mem(rd_add_value_2_mem), .mem_read_2_mem(mem_read_2_mem),
    .mem_to_reg_2_mem(mem_to_reg_2_mem), .mem_write_2_mem(mem_write_2_mem),
    .branch_taken_2_if(branch_taken_2_if), .branch_target_2_if(branch_target_2_if),
    .halt_2_if(halt_2_if), .stall_2_id(stall_2_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        mr, mtr, mw, bt;
    logic [31:0] tgt;
    logic        halt;
  } out_t;
  typedef struct { int cyc; out_t v; } oent_t;
  typedef struct { int cyc; logic v; } sent_t;

  oent_t out_q[$];
  sent_t st_q[$];
  int    cyc = 0, errors = 0, checks = 0;
  bit    mon_en = 1'b0;
  bit    m_halt = 1'b0, m_taken = 1'b0;
  out_t  act;

  always_comb act = '{alu_result_2_mem, store_data_2_mem, rd_add_value_2_mem, mem_read_2_mem,
                      mem_to_reg_2_mem, mem_write_2_mem, branch_taken_2_if, branch_target_2_if,
                      halt_2_if};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
        sent_t s;
        s = st_q.pop_front();
        check($sformatf("stall@%0d", s.cyc), 128'(stall_2_id), 128'(s.v));
      end
      while (out_q.size() > 0 && out_q[0].cyc <= cyc) begin
        oent_t o;
        o = out_q.pop_front();
        check($sformatf("out@%0d", o.cyc), 128'(act), 128'(o.v));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction, predict its effect and hold it as long as ID would.
  task automatic issue(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic [31:0] pc4, input logic [4:0] rd,
                       input logic [2:0] ctl);
    out_t        e, bub;
    logic [31:0] b, res;
    bit          kill, taken;
    int          hold;
    opcode_f_id = op; rs_reg_value_f_id = rs; rt_reg_value_f_id = rt; i_data_f_id = imm;
    pc4_in_f_id = pc4; rd_add_value_f_id = rd;
    branch_f_id = (op >= 6'h0E && op <= 6'h10);
    {mem_read_f_id, mem_to_reg_f_id, mem_write_f_id} = ctl;
    kill  = m_halt || m_taken;
    b     = (op inside {6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h0A}) ? rt : imm;
    case (op)
      6'h00, 6'h01, 6'h0C, 6'h0D: res = rs + b;
      6'h02, 6'h03:               res = rs - b;
      6'h04, 6'h05:               res = 32'(64'(rs) * 64'(b));
      6'h06, 6'h07:               res = rs | b;
      6'h08, 6'h09:               res = rs & b;
      6'h0A, 6'h0B:               res = rs ^ b;
      default:                    res = 32'h0;
    endcase
    e = '0;
    e.halt = m_halt;
    taken = 1'b0;
    if (!kill) begin
      if (op <= 6'h0D) begin
        e.alu = res; e.sd = rt; e.rd = rd; {e.mr, e.mtr, e.mw} = ctl;
      end else if (op == 6'h0E) begin
        taken = (rs == 0); e.tgt = pc4 + imm * 4;
      end else if (op == 6'h0F) begin
        taken = (rs == rt); e.tgt = pc4 + imm * 4;
      end else if (op == 6'h10) begin
        taken = 1'b1; e.tgt = rs;
      end else if (op == 6'h11) begin
        e.halt = 1'b1;
      end
    end
    e.bt = taken;
    if (!taken) e.tgt = 32'h0;
    hold = 1;
`ifdef MUL_ITERATIVE_EN
    if (!kill && (op == 6'h04 || op == 6'h05)) begin
      bub = '0;
      bub.halt = m_halt;
      for (int k = 0; k <= 32; k++) begin
        st_q.push_back('{cyc + k, 1'b1});
        out_q.push_back('{cyc + k + 1, bub});
      end
      st_q.push_back('{cyc + 33, 1'b0});
      out_q.push_back('{cyc + 34, e});
      hold = 34;
    end else
`endif
    begin
      bub = '0;
      st_q.push_back('{cyc, 1'b0});
      out_q.push_back('{cyc + 1, e});
    end
    m_halt  = e.halt;
    m_taken = taken;
    repeat (hold) step();
  endtask

  task automatic issue_random();
    logic [5:0]  op;
    logic [31:0] rs, rt, imm;
    op = 6'($urandom_range(0, 19));
    if (op == 6'h11) op = 6'h3F;
    rs  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
    rt  = ($urandom_range(0, 3) == 0) ? rs : $urandom();
    imm = ($urandom_range(0, 1) == 0) ? 32'($signed(8'($urandom()))) : $urandom();
    issue(op, rs, rt, imm, $urandom() & 32'hFFFF_FFFC, 5'($urandom()), 3'($urandom()));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    {pc4_in_f_id, rs_reg_value_f_id, rt_reg_value_f_id, i_data_f_id} = '0;
    opcode_f_id = 6'h3F; rd_add_value_f_id = '0;
    {branch_f_id, mem_read_f_id, mem_to_reg_f_id, mem_write_f_id} = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 128'(act), 128'(0));
    check("reset_stall", 128'(stall_2_id), 128'(0));
    reset  = 1'b1;
    mon_en = 1'b1;

    issue(6'h00, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h4, 5'd5, 3'b010);
    check("add_wrap_alu", 128'(alu_result_2_mem), 128'(0));
    check("add_wrap_rd", 128'(rd_add_value_2_mem), 128'(5));
    check("add_wrap_mtr", 128'(mem_to_reg_2_mem), 128'(1));
    issue(6'h03, 32'h3, 32'h0, 32'hFFFF_FFFE, 32'h8, 5'd6, 3'b010);
    check("subi_alu", 128'(alu_result_2_mem), 128'(5));
    issue(6'h0F, 32'h7, 32'h7, 32'h4, 32'h100, 5'd9, 3'b000);
    check("beq_taken", 128'(branch_taken_2_if), 128'(1));
    check("beq_target", 128'(branch_target_2_if), 128'(32'h110));
    issue(6'h00, 32'h11, 32'h22, 32'h0, 32'h104, 5'd3, 3'b010);
    check("squash_rd", 128'(rd_add_value_2_mem), 128'(0));
    check("squash_taken", 128'(branch_taken_2_if), 128'(0));
    issue(6'h05, 32'h0001_0000, 32'h0, 32'h0001_0000, 32'h108, 5'd7, 3'b010);
    check("muli_wrap", 128'(alu_result_2_mem), 128'(0));
    check("muli_rd", 128'(rd_add_value_2_mem), 128'(7));
    issue(6'h0D, 32'h40, 32'hDEAD, 32'h8, 32'h10C, 5'd0, 3'b001);
    check("stw_addr", 128'(alu_result_2_mem), 128'(32'h48));
    check("stw_data", 128'(store_data_2_mem), 128'(32'hDEAD));
    check("stw_mw", 128'(mem_write_2_mem), 128'(1));
    issue(6'h04, 32'd12345, 32'd678, 32'h0, 32'h110, 5'd8, 3'b010);
    check("mul_small", 128'(alu_result_2_mem), 128'(32'd8369910));

    repeat (250) issue_random();

    // Reset in the middle of a multiply.
    issue(6'h3F, '0, '0, '0, '0, '0, 3'b000);
    step();
    mon_en = 1'b0;
    opcode_f_id = 6'h05; rs_reg_value_f_id = 32'h1234; i_data_f_id = 32'h5678;
    repeat (10) step();
`ifdef MUL_ITERATIVE_EN
    check("stall_mid_mul", 128'(stall_2_id), 128'(1));
`endif
    #2 reset = 1'b0;
    #1;
    check("midreset_outputs", 128'(act), 128'(0));
    check("midreset_stall", 128'(stall_2_id), 128'(0));
    opcode_f_id = 6'h3F;
    @(posedge clk);
    #1;
    reset   = 1'b1;
    m_halt  = 1'b0;
    m_taken = 1'b0;
    mon_en  = 1'b1;
    issue(6'h05, 32'h3, 32'h0, 32'h7, 32'h0, 5'd4, 3'b010);
    check("mul_after_reset", 128'(alu_result_2_mem), 128'(21));
    repeat (20) issue_random();

    // HALT is sticky; everything after it is a bubble.
    issue(6'h11, '0, '0, '0, '0, '0, 3'b000);
    check("halt_set", 128'(halt_2_if), 128'(1));
    issue(6'h00, 32'h5, 32'h6, 32'h0, 32'h0, 5'd2, 3'b010);
    check("halt_bubble_alu", 128'(alu_result_2_mem), 128'(0));
    check("halt_bubble_rd", 128'(rd_add_value_2_mem), 128'(0));
    check("halt_sticky", 128'(halt_2_if), 128'(1));
    issue(6'h10, 32'h80, '0, '0, '0, '0, 3'b000);
    repeat (10) issue_random();
    step();
    mon_en = 1'b0;
    check("queue_out_empty", 128'(out_q.size()), 128'(0));
    check("queue_stall_empty", 128'(st_q.size()), 128'(0));
    reset = 1'b0;
    #1;
    check("final_reset_halt", 128'(halt_2_if), 128'(0));
    check("final_reset_outputs", 128'(act), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
